// File: rtl/key_map_pkg.sv
// Shared constants and the priority encoder for the vending-panel key mapper.
package key_map_pkg;

  localparam int KEY_W  = 6;
  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] KEY_NONE = 3'd0;
  localparam logic [CODE_W-1:0] KEY_1    = 3'd1;
  localparam logic [CODE_W-1:0] KEY_2    = 3'd2;
  localparam logic [CODE_W-1:0] KEY_3    = 3'd3;
  localparam logic [CODE_W-1:0] KEY_4    = 3'd4;
  localparam logic [CODE_W-1:0] KEY_5    = 3'd5;
  localparam logic [CODE_W-1:0] KEY_6    = 3'd6;

  // Scan upward so the highest set bit (leftmost key, lowest code) wins.
  function automatic logic [CODE_W-1:0] encode_key(input logic [KEY_W-1:0] vec);
    logic [CODE_W-1:0] code;
    code = KEY_NONE;
    for (int i = 0; i < KEY_W; i++) begin
      if (vec[i]) code = CODE_W'(KEY_W - i);
    end
    return code;
  endfunction

  function automatic logic multi_key(input logic [KEY_W-1:0] vec);
    return (vec & (vec - KEY_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-bit input synchroniser followed by a whole-vector debouncer for the key bus.
module key_debounce
  import key_map_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0] sync_reg [SYNC_STAGES];
  logic [KEY_W-1:0] sample_reg;
  logic [KEY_W-1:0] db_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [KEY_W-1:0] sync_vec;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= key_in;
        end else begin
          sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign sync_vec = sync_reg[SYNC_STAGES-1];

  // Any change restarts the stability window; the vector is accepted once it has held long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg <= '0;
      cnt_reg    <= '0;
      db_reg     <= '0;
    end else if (sync_vec != sample_reg) begin
      sample_reg <= sync_vec;
      cnt_reg    <= '0;
    end else begin
      if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
      if (cnt_reg == CNT_LOAD) db_reg <= sample_reg;
    end
  end

  assign key_db = db_reg;

endmodule

// File: rtl/key_mapper.sv
// Vending-panel key mapper: debounced six-key bus to a 3-bit code with a press strobe.
// Define KEY_MAP_MULTI_ERR_EN to add key_err and blank the code while several keys are down.
module key_mapper
  import key_map_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key_in,
  output logic [CODE_W-1:0] key_out,
`ifdef KEY_MAP_MULTI_ERR_EN
  output logic              key_err,
`endif
  output logic              key_valid,
  output logic              key_held
);

  logic [KEY_W-1:0]  key_db;
  logic [CODE_W-1:0] code_next;
  logic [CODE_W-1:0] key_out_reg;
  logic              key_valid_reg;
  logic              key_held_reg;

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .key_db (key_db)
  );

`ifdef KEY_MAP_MULTI_ERR_EN
  logic multi_next;
  logic key_err_reg;

  assign multi_next = multi_key(key_db);
  assign code_next  = multi_next ? KEY_NONE : encode_key(key_db);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_err_reg <= 1'b0;
    else        key_err_reg <= multi_next;
  end

  assign key_err = key_err_reg;
`else
  assign code_next = encode_key(key_db);
`endif

  // Strobe only on arrival of a different nonzero code; releases stay silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out_reg   <= KEY_NONE;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      key_out_reg   <= code_next;
      key_valid_reg <= (code_next != KEY_NONE) && (code_next != key_out_reg);
      key_held_reg  <= (key_db != '0);
    end
  end

  assign key_out   = key_out_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_key_mapper.sv
// Scoreboard bench for key_mapper: expected codes queued at stimulus, popped on each key_valid.
module tb_key_mapper;

  logic       clk;
  logic       rst_n;
  logic [5:0] key_in;
  logic [2:0] key_out;
  logic       key_valid;
  logic       key_held;
`ifdef KEY_MAP_MULTI_ERR_EN
  logic       key_err;
`endif

  int checks   = 0;
  int failures = 0;
  int sb[$];

  key_mapper #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_out   (key_out),
`ifdef KEY_MAP_MULTI_ERR_EN
    .key_err   (key_err),
`endif
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding expected code.
  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", int'(key_valid), 0);
      end else begin
        int exp;
        exp = sb.pop_front();
        check("strobe_code", int'(key_out), exp);
        check("strobe_held", int'(key_held), 1);
        $display("strobe key_out=%0d expected=%0d", key_out, exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, sb.size(), 0);
  endtask

  // Hold a vector, confirm the code and strobe, then release and confirm return to idle.
  task automatic press(input string tag, input logic [5:0] vec, input int exp_code);
    if (exp_code != 0) sb.push_back(exp_code);
    key_in = vec;
    idle(20);
    drain(tag, 20);
    check({"hold_code_", tag}, int'(key_out), exp_code);
    check({"hold_held_", tag}, int'(key_held), int'(vec != 6'd0));
    $display("press %s key_in=%b key_out=%0d key_held=%0d", tag, vec, key_out, key_held);
    key_in = 6'd0;
    idle(20);
    check({"release_code_", tag}, int'(key_out), 0);
    check({"release_held_", tag}, int'(key_held), 0);
  endtask

  initial begin
    logic [5:0] walk [6];
    int n;
    walk = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};

    rst_n  = 1'b0;
    key_in = 6'b100000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset_code", int'(key_out), 0);
      check("reset_valid", int'(key_valid), 0);
      check("reset_held", int'(key_held), 0);
    end
    $display("reset held 8 cycles key_out=%0d", key_out);
    key_in = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("post_reset_code", int'(key_out), 0);

    for (int i = 0; i < 6; i++) press($sformatf("walk%0d", i), walk[i], i + 1);

    // Two-cycle glitch must be absorbed.
    key_in = 6'b001000;
    idle(2);
    key_in = 6'd0;
    idle(20);
    check("glitch_code", int'(key_out), 0);
    check("glitch_queue", sb.size(), 0);
    $display("glitch 001000 x2 key_out=%0d", key_out);

`ifdef KEY_MAP_MULTI_ERR_EN
    key_in = 6'b010001;
    idle(20);
    check("multi_err", int'(key_err), 1);
    check("multi_code", int'(key_out), 0);
    $display("multi 010001 key_out=%0d key_err=%0d", key_out, key_err);
    key_in = 6'd0;
    idle(20);
    check("multi_err_clear", int'(key_err), 0);
`else
    press("multi", 6'b010001, 2);
`endif

    // Direct change between keys without release.
    sb.push_back(4);
    key_in = 6'b000100;
    idle(20);
    drain("direct4", 20);
    check("direct_code4", int'(key_out), 4);
    sb.push_back(5);
    key_in = 6'b000010;
    idle(20);
    drain("direct5", 20);
    check("direct_code5", int'(key_out), 5);
    $display("direct 000100->000010 key_out=%0d", key_out);
    key_in = 6'd0;
    idle(20);
    check("direct_release", int'(key_out), 0);

    // Asynchronous reset while a key is reported.
    sb.push_back(3);
    key_in = 6'b001000;
    n = 0;
    while (key_out != 3'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("async_pre_code", int'(key_out), 3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_code", int'(key_out), 0);
    check("async_valid", int'(key_valid), 0);
    check("async_held", int'(key_held), 0);
    $display("async reset mid-press key_out=%0d key_held=%0d", key_out, key_held);
    sb.delete();
    key_in = 6'd0;
    idle(3);
    rst_n = 1'b1;
    idle(15);
    check("after_async_code", int'(key_out), 0);
    check("final_queue", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
